// File: rtl/bmu_result_queue.sv
// BMU result capture and writeback FIFO with error/overflow tracking.
// Optional build macro BMU_RQ_ERR_DROP_EN: erroring results are counted but never queued.
module bmu_result_queue #(
  parameter int DEPTH = 4,
  parameter int RDW   = 5
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     bmu_valid_in,
  input  logic [RDW-1:0]           bmu_rd_in,
  input  logic [31:0]              result_in,
  input  logic                     error_in,
  input  logic                     flush,
  input  logic                     clr_ovf,
  input  logic                     wb_ready,
  output logic                     wb_valid,
  output logic [31:0]              wb_data,
  output logic [RDW-1:0]           wb_rd,
  output logic                     wb_error,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [15:0]              err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef BMU_RQ_ERR_DROP_EN
  typedef struct packed {
    logic [RDW-1:0] rd;
    logic [31:0]    data;
  } entry_t;
`else
  typedef struct packed {
    logic [RDW-1:0] rd;
    logic [31:0]    data;
    logic           err;
  } entry_t;
`endif

  entry_t          mem_q [DEPTH];
  logic            cap_v_q, cap_v_d;
  logic [RDW-1:0]  cap_rd_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     errc_q, errc_d;

  logic            pop;
  logic            push;
  logic            storable;
  logic            room;
  logic            ovf_set;
  entry_t          push_entry;
  entry_t          head;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pop        = 1'b0;
    push       = 1'b0;
    storable   = 1'b0;
    room       = 1'b0;
    ovf_set    = 1'b0;
    cap_v_d    = bmu_valid_in;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    errc_d     = errc_q;

`ifdef BMU_RQ_ERR_DROP_EN
    storable   = cap_v_q && !error_in;
    push_entry = '{rd: cap_rd_q, data: result_in};
`else
    storable   = cap_v_q;
    push_entry = '{rd: cap_rd_q, data: result_in, err: error_in};
`endif

    pop     = (count_q != '0) && wb_ready && !flush;
    room    = (count_q != CW'(DEPTH)) || pop;
    push    = storable && room && !flush;
    // A capture discarded by flush is not a capacity loss, so it never flags overflow.
    ovf_set = storable && !room && !flush;

    if (cap_v_q && error_in && (errc_q != 16'hFFFF)) begin
      errc_d = errc_q + 16'd1;
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    if (flush) begin
      cap_v_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cap_v_q  <= 1'b0;
      cap_rd_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      errc_q   <= '0;
    end else begin
      cap_v_q  <= cap_v_d;
      cap_rd_q <= bmu_rd_in;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      errc_q   <= errc_d;
    end
  end

  // NOTE: storage is reset on purpose so the head outputs read 0 after reset; small DEPTH keeps this cheap.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Head outputs come straight from storage; wb_ready only affects next-state logic.
  assign head      = mem_q[rd_ptr_q];
  assign wb_valid  = (count_q != '0);
  assign wb_data   = head.data;
  assign wb_rd     = head.rd;
`ifdef BMU_RQ_ERR_DROP_EN
  assign wb_error  = 1'b0;
`else
  assign wb_error  = head.err;
`endif
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign overflow  = ovf_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_bmu_result_queue.sv
// Self-checking bench for bmu_result_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bmu_result_queue;

  localparam int DEPTH = 4;
  localparam int RDW   = 5;
`ifdef BMU_RQ_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_l = 1'b0;
  logic                   bmu_valid_in = 1'b0;
  logic [RDW-1:0]         bmu_rd_in = '0;
  logic [31:0]            result_in = '0;
  logic                   error_in = 1'b0;
  logic                   flush = 1'b0;
  logic                   clr_ovf = 1'b0;
  logic                   wb_ready = 1'b0;
  logic                   wb_valid;
  logic [31:0]            wb_data;
  logic [RDW-1:0]         wb_rd;
  logic                   wb_error;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   overflow;
  logic [15:0]            err_count;

  bmu_result_queue #(.DEPTH(DEPTH), .RDW(RDW)) dut (
    .clk(clk), .rst_l(rst_l), .bmu_valid_in(bmu_valid_in), .bmu_rd_in(bmu_rd_in),
    .result_in(result_in), .error_in(error_in), .flush(flush), .clr_ovf(clr_ovf),
    .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_error(wb_error), .count(count), .full(full), .overflow(overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus the one-deep capture stage.
  typedef struct {
    logic [RDW-1:0] rd;
    logic [31:0]    data;
    logic           err;
  } ent_t;

  ent_t           mq[$];
  bit             m_cap_v = 1'b0;
  logic [RDW-1:0] m_cap_rd = '0;
  bit             m_ovf = 1'b0;
  int             m_errc = 0;

  task automatic model_edge(input bit v, input logic [RDW-1:0] rd, input bit rdy,
                            input bit fl, input bit clr, input bit rstn);
    bit lost;
    lost = 1'b0;
    if (!rstn) begin
      mq.delete();
      m_cap_v = 1'b0;
      m_ovf   = 1'b0;
      m_errc  = 0;
    end else begin
      if (m_cap_v && error_in && m_errc < 65535) m_errc++;
      if (fl) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (m_cap_v && !(DROP && error_in)) begin
          if (mq.size() < DEPTH) mq.push_back('{rd: m_cap_rd, data: result_in, err: DROP ? 1'b0 : error_in});
          else lost = 1'b1;
        end
      end
      if (lost) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_cap_v  = fl ? 1'b0 : v;
      m_cap_rd = rd;
    end
  endtask

  task automatic compare_model();
    check("wb_valid", wb_valid, mq.size() > 0);
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("err_count", err_count, m_errc);
    if (mq.size() > 0) begin
      check("wb_data", wb_data, mq[0].data);
      check("wb_rd", wb_rd, mq[0].rd);
      check("wb_error", wb_error, mq[0].err);
    end
  endtask

  // One clock: drive inputs, advance the model, then act as the BMU result register.
  task automatic step(input bit v, input logic [RDW-1:0] rd, input logic [31:0] a,
                      input logic [31:0] b, input bit rdy, input bit fl,
                      input bit clr, input bit rstn);
    logic [31:0] s;
    bmu_valid_in = v;
    bmu_rd_in    = rd;
    wb_ready     = rdy;
    flush        = fl;
    clr_ovf      = clr;
    rst_l        = rstn;
    model_edge(v, rd, rdy, fl, clr, rstn);
    @(posedge clk);
    #1;
    s = a + b;
    if (v) begin
      result_in = s;
      error_in  = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      result_in = $urandom;
      error_in  = $urandom_range(0, 1) == 1;
    end
    compare_model();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, '0, '0, rdy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [RDW-1:0] rd, input logic [31:0] a, input logic [31:0] b, input bit rdy);
    step(1'b1, rd, a, b, rdy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int e0;

  initial begin
    #2;
    do_reset();
    check("rst_wb_data", wb_data, 32'h0);

    // Latency: one-cycle wb_valid pulse two edges after issue.
    issue(5'd3, 32'd5, 32'd7, 1'b1);
    check("lat_edge1_valid", wb_valid, 1'b0);
    idle(1'b1);
    check("lat_valid", wb_valid, 1'b1);
    check("lat_data", wb_data, 32'd12);
    check("lat_rd", wb_rd, 5'd3);
    check("lat_err", wb_error, 1'b0);
    idle(1'b1);
    check("lat_pulse_end", wb_valid, 1'b0);

    // Reset mid-operation: queued and in-flight ops vanish.
    issue(5'd1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    issue(5'd2, 32'd2, 32'd2, 1'b0);
    issue(5'd4, 32'd3, 32'd3, 1'b0);
    step(1'b1, 5'd5, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_count", count, 0);
    check("rst_valid", wb_valid, 1'b0);
    check("rst_errc", err_count, 16'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_data", wb_data, 32'h0);
    issue(5'd7, 32'd40, 32'd2, 1'b0);
    check("rel_edge1_valid", wb_valid, 1'b0);
    idle(1'b0);
    check("rel_valid", wb_valid, 1'b1);
    check("rel_data", wb_data, 32'd42);
    check("rel_rd", wb_rd, 5'd7);

    // Error path.
    do_reset();
    issue(5'd9, 32'h7FFF_FFFF, 32'd1, 1'b0);
    idle(1'b0);
    check("err_count1", err_count, 16'd1);
`ifdef BMU_RQ_ERR_DROP_EN
    check("err_drop_count", count, 0);
`else
    check("err_data", wb_data, 32'h8000_0000);
    check("err_flag", wb_error, 1'b1);
    check("err_rd", wb_rd, 5'd9);
`endif

    // Fill and overflow.
    do_reset();
    for (int i = 1; i <= 5; i++) issue(RDW'(i), 32'(i), 32'd0, 1'b0);
    idle(1'b0);
    check("fill_full", full, 1'b1);
    check("fill_count", count, DEPTH);
    check("fill_ovf", overflow, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", wb_data, 32'(i));
      idle(1'b1);
    end
    check("drain_empty", wb_valid, 1'b0);
    idle(1'b1);
    check("ovf_sticky", overflow, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovf_cleared", overflow, 1'b0);

    // Full with simultaneous pop, across pointer wrap.
    for (int i = 0; i < 5; i++) issue(RDW'(i + 10), 32'(100 + i), 32'd0, 1'b0);
    check("fp_full", full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      issue(RDW'(i + 20), 32'(200 + i), 32'd0, 1'b1);
      check("fp_count", count, DEPTH);
      check("fp_ovf", overflow, 1'b0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Flush with 3 queued and 1 in flight.
    issue(5'd1, 32'd11, 32'd0, 1'b0);
    issue(5'd2, 32'd22, 32'd0, 1'b0);
    issue(5'd3, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(5'd4, 32'd44, 32'd0, 1'b0);
    check("pre_flush_count", count, 3);
    e0 = m_errc;
    step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("flush_count", count, 0);
    check("flush_errc", err_count, e0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("flush_inflight_gone", wb_valid, 1'b0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bit v, rdy, fl, clr, rstn;
      logic [31:0] a, b;
      v    = $urandom_range(0, 3) != 0;
      rdy  = (n / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      fl   = $urandom_range(0, 39) == 0;
      clr  = $urandom_range(0, 19) == 0;
      rstn = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 3) == 0) begin
        a = 32'h7FFF_FFF0 + $urandom_range(0, 15);
        b = $urandom_range(0, 31);
      end else begin
        a = $urandom;
        b = $urandom;
      end
      step(v, RDW'($urandom), a, b, rdy, fl, clr, rstn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
